// File: rtl/spi_target.sv
// spi_target: SPI mode-0 target (slave) core, MSB first, 8-bit bytes.
// All SPI pins are oversampled in the clk domain. Received bytes are
// returned on rx_byte_o/rx_en_o; transmit bytes are taken through a
// one-byte holding register with a tx_ready_o/tx_en_i handshake.
//
// Ports:
//   clk, reset        system clock, synchronous active-high reset
//   spi_clk_i         SCK from the external host (asynchronous)
//   spi_csn_i         chip select, active low (asynchronous)
//   spi_mosi_i        MOSI (asynchronous)
//   spi_miso_o        MISO data (registered)
//   spi_miso_drive_o  MISO output enable, high while selected
//   tx_byte_i/tx_en_i write the holding register when tx_ready_o=1
//   tx_ready_o        holding register empty
//   rx_byte_o/rx_en_o last complete received byte / one-cycle update pulse
//   sel_o             frame active
//   frame_start_o     one-cycle pulse at frame start
//   frame_end_o       one-cycle pulse at frame end
//   tx_underrun_o     one-cycle pulse when IDLE_BYTE was loaded
//
// state     | meaning
// ----------+---------------------------------------------------------
// WAIT_HIGH | after reset; wait for a genuinely sampled CSn high
// IDLE      | not selected; waiting for CSn falling edge
// ACTIVE    | selected; shifting on SCK edges until CSn rises
module spi_target #(
  parameter int         SYNC_STAGES = 2,
  parameter logic [7:0] IDLE_BYTE   = 8'hFF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       spi_clk_i,
  input  logic       spi_csn_i,
  input  logic       spi_mosi_i,
  output logic       spi_miso_o,
  output logic       spi_miso_drive_o,
  input  logic [7:0] tx_byte_i,
  input  logic       tx_en_i,
  output logic       tx_ready_o,
  output logic [7:0] rx_byte_o,
  output logic       rx_en_o,
  output logic       sel_o,
  output logic       frame_start_o,
  output logic       frame_end_o,
  output logic       tx_underrun_o
);

  typedef enum logic [1:0] {
    ST_WAIT_HIGH = 2'd0,
    ST_IDLE      = 2'd1,
    ST_ACTIVE    = 2'd2
  } state_t;

  // The flush counter runs until every synchronizer and edge flop holds a
  // value taken from the pins rather than its reset value. Without it the
  // csn chain's reset value of 1 would look like a CSn falling edge when
  // the host holds CSn low through reset release.
  localparam int FLUSH_W = $clog2(SYNC_STAGES + 2);
  localparam logic [FLUSH_W-1:0] FLUSH_MAX = FLUSH_W'(SYNC_STAGES + 1);

  logic [SYNC_STAGES-1:0] sck_sync;
  logic [SYNC_STAGES-1:0] csn_sync;
  logic [SYNC_STAGES-1:0] mosi_sync;
  logic                   sck_d;
  logic                   csn_d;
  logic [FLUSH_W-1:0]     flush_cnt;

  logic sck_s, csn_s, mosi_s;
  logic sck_rise, sck_fall, csn_rise, csn_fall;
  logic flushed;

  state_t state, state_nx;
  logic   start_frame, end_frame, sck_rise_act, sck_fall_act, byte_load;

  logic [2:0] bit_cnt;
  logic       byte_done;
  logic [7:0] rx_shift;
  logic [7:0] rx_nx;
  logic [7:0] tx_shift;
  logic [7:0] hold;
  logic       hold_full;

  // ---------------------------------------------------------------
  // Synchronizers and edge detection
  // ---------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      sck_sync  <= '0;
      csn_sync  <= '1;
      mosi_sync <= '0;
      sck_d     <= 1'b0;
      csn_d     <= 1'b1;
      flush_cnt <= '0;
    end else begin
      sck_sync  <= {sck_sync[SYNC_STAGES-2:0], spi_clk_i};
      csn_sync  <= {csn_sync[SYNC_STAGES-2:0], spi_csn_i};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi_i};
      sck_d     <= sck_sync[SYNC_STAGES-1];
      csn_d     <= csn_sync[SYNC_STAGES-1];
      if (flush_cnt != FLUSH_MAX)
        flush_cnt <= flush_cnt + 1'b1;
    end
  end

  assign sck_s    = sck_sync[SYNC_STAGES-1];
  assign csn_s    = csn_sync[SYNC_STAGES-1];
  assign mosi_s   = mosi_sync[SYNC_STAGES-1];
  assign sck_rise =  sck_s & ~sck_d;
  assign sck_fall = ~sck_s &  sck_d;
  assign csn_rise =  csn_s & ~csn_d;
  assign csn_fall = ~csn_s &  csn_d;
  assign flushed  = (flush_cnt == FLUSH_MAX);

  // ---------------------------------------------------------------
  // Frame state machine
  // ---------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset)
      state <= ST_WAIT_HIGH;
    else
      state <= state_nx;
  end

  always_comb begin
    state_nx     = state;
    start_frame  = 1'b0;
    end_frame    = 1'b0;
    sck_rise_act = 1'b0;
    sck_fall_act = 1'b0;
    unique case (state)
      ST_WAIT_HIGH: begin
        if (flushed && csn_s)
          state_nx = ST_IDLE;
      end
      ST_IDLE: begin
        if (csn_fall) begin
          state_nx    = ST_ACTIVE;
          start_frame = 1'b1;
        end
      end
      ST_ACTIVE: begin
        // CSn deassert wins over an SCK edge seen in the same cycle.
        if (csn_rise) begin
          state_nx  = ST_IDLE;
          end_frame = 1'b1;
        end else if (sck_rise) begin
          sck_rise_act = 1'b1;
        end else if (sck_fall) begin
          sck_fall_act = 1'b1;
        end
      end
      default: state_nx = ST_WAIT_HIGH;
    endcase
  end

  assign byte_load = start_frame | (sck_fall_act & byte_done);
  assign rx_nx     = {rx_shift[6:0], mosi_s};

  // ---------------------------------------------------------------
  // Shift registers, holding register and status pulses
  // ---------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      bit_cnt       <= 3'd0;
      byte_done     <= 1'b0;
      rx_shift      <= 8'h00;
      tx_shift      <= 8'h00;
      hold          <= 8'h00;
      hold_full     <= 1'b0;
      rx_byte_o     <= 8'h00;
      rx_en_o       <= 1'b0;
      frame_start_o <= 1'b0;
      frame_end_o   <= 1'b0;
      tx_underrun_o <= 1'b0;
      spi_miso_o    <= 1'b0;
    end else begin
      rx_en_o       <= 1'b0;
      frame_start_o <= start_frame;
      frame_end_o   <= end_frame;
      tx_underrun_o <= byte_load & ~hold_full;

      // Partial bytes are dropped at either end of a frame.
      if (start_frame || end_frame) begin
        bit_cnt   <= 3'd0;
        byte_done <= 1'b0;
        rx_shift  <= 8'h00;
      end

      if (sck_rise_act) begin
        rx_shift <= rx_nx;
        bit_cnt  <= bit_cnt + 3'd1;
        if (bit_cnt == 3'd7) begin
          rx_byte_o <= rx_nx;
          rx_en_o   <= 1'b1;
          byte_done <= 1'b1;
        end
      end

      if (byte_load) begin
        byte_done <= 1'b0;
        if (hold_full) begin
          tx_shift  <= hold;
          hold_full <= 1'b0;
        end else begin
          tx_shift <= IDLE_BYTE;
        end
      end else if (sck_fall_act) begin
        tx_shift <= {tx_shift[6:0], 1'b0};
      end

      // Only accepted while empty, so it never collides with the load
      // above emptying a full register; a write racing a load of an empty
      // register is kept for the following load.
      if (tx_en_i && !hold_full) begin
        hold      <= tx_byte_i;
        hold_full <= 1'b1;
      end

      spi_miso_o <= (state == ST_ACTIVE) & tx_shift[7];
    end
  end

  assign tx_ready_o       = ~hold_full;
  assign sel_o            = (state == ST_ACTIVE);
  assign spi_miso_drive_o = sel_o;

endmodule

// File: tb/tb_spi_target.sv
// tb_spi_target: directed bench for spi_target. A behavioural mode-0 host
// drives SCK/CSn/MOSI with a 4-clk half-period and samples MISO just before
// each rising edge. A negedge monitor counts output pulses and logs bytes.
module tb_spi_target;

  logic       clk;
  logic       reset;
  logic       spi_clk_i;
  logic       spi_csn_i;
  logic       spi_mosi_i;
  logic       spi_miso_o;
  logic       spi_miso_drive_o;
  logic [7:0] tx_byte_i;
  logic       tx_en_i;
  logic       tx_ready_o;
  logic [7:0] rx_byte_o;
  logic       rx_en_o;
  logic       sel_o;
  logic       frame_start_o;
  logic       frame_end_o;
  logic       tx_underrun_o;

  spi_target #(.SYNC_STAGES(2), .IDLE_BYTE(8'hFF)) dut (
    .clk              (clk),
    .reset            (reset),
    .spi_clk_i        (spi_clk_i),
    .spi_csn_i        (spi_csn_i),
    .spi_mosi_i       (spi_mosi_i),
    .spi_miso_o       (spi_miso_o),
    .spi_miso_drive_o (spi_miso_drive_o),
    .tx_byte_i        (tx_byte_i),
    .tx_en_i          (tx_en_i),
    .tx_ready_o       (tx_ready_o),
    .rx_byte_o        (rx_byte_o),
    .rx_en_o          (rx_en_o),
    .sel_o            (sel_o),
    .frame_start_o    (frame_start_o),
    .frame_end_o      (frame_end_o),
    .tx_underrun_o    (tx_underrun_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  int n_rx = 0, n_fs = 0, n_fe = 0, n_ur = 0, n_sel = 0, n_drv = 0;
  logic [7:0] rx_log[$];

  always @(negedge clk) begin
    if (rx_en_o) begin
      n_rx++;
      rx_log.push_back(rx_byte_o);
    end
    if (frame_start_o)    n_fs++;
    if (frame_end_o)      n_fe++;
    if (tx_underrun_o)    n_ur++;
    if (sel_o)            n_sel++;
    if (spi_miso_drive_o) n_drv++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tx_write(input logic [7:0] b);
    @(negedge clk);
    tx_byte_i = b;
    tx_en_i   = 1'b1;
    @(negedge clk);
    tx_en_i   = 1'b0;
  endtask

  // Byte b of the frame lives in bits [8*b +: 8]. The last SCK fall and
  // the CSn deassert happen together, so no load follows the final byte.
  task automatic spi_frame(input int n, input logic [31:0] mosi_w, output logic [31:0] miso_w);
    logic [7:0] tb_byte;
    miso_w    = '0;
    spi_csn_i = 1'b0;
    repeat (4) @(negedge clk);
    for (int b = 0; b < n; b++) begin
      tb_byte = mosi_w[8*b +: 8];
      for (int i = 7; i >= 0; i--) begin
        spi_mosi_i = tb_byte[i];
        repeat (4) @(negedge clk);
        miso_w[8*b + i] = spi_miso_o;
        spi_clk_i = 1'b1;
        repeat (4) @(negedge clk);
        spi_clk_i = 1'b0;
        if (b == n - 1 && i == 0)
          spi_csn_i = 1'b1;
      end
    end
    spi_mosi_i = 1'b0;
    repeat (10) @(negedge clk);
  endtask

  task automatic sck_pulses(input int n);
    for (int i = 0; i < n; i++) begin
      spi_mosi_i = 1'b1;
      repeat (4) @(negedge clk);
      spi_clk_i = 1'b1;
      repeat (4) @(negedge clk);
      spi_clk_i = 1'b0;
    end
    spi_mosi_i = 1'b0;
  endtask

  initial begin
    #200us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] miso_w;
    int rx0, fs0, fe0, ur0, sel0, drv0, base;
    bit  got_ready;

    reset      = 1'b1;
    spi_clk_i  = 1'b0;
    spi_csn_i  = 1'b0;
    spi_mosi_i = 1'b0;
    tx_byte_i  = 8'h00;
    tx_en_i    = 1'b0;
    repeat (5) @(negedge clk);

    // Reset values
    check("rst_miso",     spi_miso_o,       0);
    check("rst_drive",    spi_miso_drive_o, 0);
    check("rst_ready",    tx_ready_o,       1);
    check("rst_rx_byte",  rx_byte_o,        0);
    check("rst_rx_en",    rx_en_o,          0);
    check("rst_sel",      sel_o,            0);
    check("rst_fstart",   frame_start_o,    0);
    check("rst_fend",     frame_end_o,      0);
    check("rst_underrun", tx_underrun_o,    0);

    // CSn held low through reset release never starts a frame
    rx0 = n_rx; fs0 = n_fs; sel0 = n_sel; drv0 = n_drv;
    reset = 1'b0;
    repeat (10) @(negedge clk);
    sck_pulses(8);
    repeat (10) @(negedge clk);
    check("csn_low_rx_en",  n_rx - rx0,   0);
    check("csn_low_fstart", n_fs - fs0,   0);
    check("csn_low_sel",    n_sel - sel0, 0);
    check("csn_low_drive",  n_drv - drv0, 0);
    spi_csn_i = 1'b1;
    repeat (10) @(negedge clk);

    // Single byte: send A5, host sends 3C
    tx_write(8'hA5);
    check("single_ready_low", tx_ready_o, 0);
    rx0 = n_rx; fs0 = n_fs; fe0 = n_fe; ur0 = n_ur;
    spi_frame(1, 32'h0000_003C, miso_w);
    check("single_host_rx", miso_w[7:0],  8'hA5);
    check("single_rx_byte", rx_byte_o,    8'h3C);
    check("single_rx_en",   n_rx - rx0,   1);
    check("single_fstart",  n_fs - fs0,   1);
    check("single_fend",    n_fe - fe0,   1);
    check("single_ready",   tx_ready_o,   1);
    check("single_underrun", n_ur - ur0,  0);
    check("single_sel_off", sel_o,        0);
    check("single_miso_off", spi_miso_o,  0);

    // Back-to-back: preload 12, write 34 as soon as ready rises
    tx_write(8'h12);
    rx0 = n_rx; ur0 = n_ur; base = rx_log.size();
    got_ready = 1'b0;
    fork
      spi_frame(2, 32'h0000_0FC0, miso_w);
      begin
        for (int c = 0; c < 200 && !got_ready; c++) begin
          @(negedge clk);
          if (tx_ready_o) got_ready = 1'b1;
        end
        if (got_ready) begin
          tx_byte_i = 8'h34;
          tx_en_i   = 1'b1;
          @(negedge clk);
          tx_en_i   = 1'b0;
        end
      end
    join
    check("b2b_ready_seen", got_ready,       1);
    check("b2b_host_rx0",   miso_w[7:0],     8'h12);
    check("b2b_host_rx1",   miso_w[15:8],    8'h34);
    check("b2b_rx_en",      n_rx - rx0,      2);
    check("b2b_rx0",        rx_log[base],    8'hC0);
    check("b2b_rx1",        rx_log[base+1],  8'h0F);
    check("b2b_underrun",   n_ur - ur0,      0);

    // Underrun: only 55 preloaded for a two-byte frame
    tx_write(8'h55);
    ur0 = n_ur;
    spi_frame(2, 32'h0000_6699, miso_w);
    check("ur_host_rx0",  miso_w[7:0],  8'h55);
    check("ur_host_rx1",  miso_w[15:8], 8'hFF);
    check("ur_count",     n_ur - ur0,   1);
    check("ur_ready",     tx_ready_o,   1);

    // Abort after 5 SCK cycles, then a clean frame of 81
    rx0 = n_rx; fe0 = n_fe;
    spi_csn_i = 1'b0;
    repeat (4) @(negedge clk);
    sck_pulses(5);
    repeat (4) @(negedge clk);
    spi_csn_i = 1'b1;
    repeat (10) @(negedge clk);
    check("abort_rx_en", n_rx - rx0, 0);
    check("abort_fend",  n_fe - fe0, 1);
    rx0 = n_rx;
    spi_frame(1, 32'h0000_0081, miso_w);
    check("abort_next_rx_en", n_rx - rx0, 1);
    check("abort_next_rx",    rx_byte_o,  8'h81);

    // Reset mid-frame with a byte waiting in the holding register
    tx_write(8'hAA);
    spi_csn_i = 1'b0;
    repeat (4) @(negedge clk);
    sck_pulses(3);
    tx_write(8'hBB);
    check("midrst_hold_full", tx_ready_o, 0);
    reset      = 1'b1;
    spi_csn_i  = 1'b1;
    repeat (3) @(negedge clk);
    check("midrst_sel",   sel_o,      0);
    check("midrst_ready", tx_ready_o, 1);
    check("midrst_miso",  spi_miso_o, 0);
    reset = 1'b0;
    repeat (10) @(negedge clk);
    check("midrst_ready_after", tx_ready_o, 1);
    tx_write(8'h77);
    rx0 = n_rx;
    spi_frame(1, 32'h0000_005A, miso_w);
    check("midrst_host_rx", miso_w[7:0], 8'h77);
    check("midrst_rx_byte", rx_byte_o,   8'h5A);
    check("midrst_rx_en",   n_rx - rx0,  1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_target.md
Name: spi_target

Overview:
- SPI target (slave) core: the far end of our SPI master, for cases where NORA is addressed by an external SPI host (debug/programming link).
- SPI mode 0 only (CPOL=0, CPHA=0), MSB first, 8-bit bytes.
- All SPI pins are oversampled in the system clock domain. The block returns received bytes, and takes transmit bytes through a one-byte holding register with a ready/enable handshake.
- A register-interface wrapper with FIFOs sits above this block. It is not part of this block.

Parameters:
- SYNC_STAGES, 2, number of synchronizer flops on each SPI input pin (minimum 2).
- IDLE_BYTE, 8'hFF, byte shifted out when the TX holding register is empty at a byte load.

Ports:
- clk  in  1  system clock, 48MHz.
- reset  in  1  synchronous, active-high reset.
- spi_clk_i  in  1  SCK from the external host, asynchronous.
- spi_csn_i  in  1  chip select from the external host, active low, asynchronous.
- spi_mosi_i  in  1  MOSI from the external host, asynchronous.
- spi_miso_o  out  1  MISO data.
- spi_miso_drive_o  out  1  MISO output enable; high only while selected.
- tx_byte_i  in  8  next byte to transmit.
- tx_en_i  in  1  write tx_byte_i into the holding register; honoured only when tx_ready_o=1.
- tx_ready_o  out  1  holding register is empty.
- rx_byte_o  out  8  last complete received byte.
- rx_en_o  out  1  one-cycle pulse: rx_byte_o has just been updated.
- sel_o  out  1  a frame is active.
- frame_start_o  out  1  one-cycle pulse at frame start.
- frame_end_o  out  1  one-cycle pulse at frame end.
- tx_underrun_o  out  1  one-cycle pulse: IDLE_BYTE was loaded because the holding register was empty.

Behaviour:
- Synchronization:
  - Each pin passes through SYNC_STAGES flops, plus one extra flop for edge detection.
  - Reset values of the sync chains: clk=0, csn=1, mosi=0.
  - Edge detect latency is SYNC_STAGES+1 clk cycles from the pin edge. MOSI uses the same stage count, so it stays aligned with SCK.
- Timing requirement: the SCK high and low phases must each be at least SYNC_STAGES+2 clk cycles. At 48MHz with SYNC_STAGES=2, SCK is at most 6MHz. Behaviour above this limit is undefined.
- Reset values:
  - spi_miso_o=0, spi_miso_drive_o=0, tx_ready_o=1, rx_byte_o=0.
  - rx_en_o, frame_start_o, frame_end_o, tx_underrun_o, sel_o all 0.
  - Bit counter = 0, shift registers = 0, holding register empty, state=WAIT_HIGH.
- State machine:
  - WAIT_HIGH: entered after reset. Leave to IDLE once synced csn=1. A CSn already low at reset never starts a frame.
  - IDLE: on synced csn falling edge:
    - go to ACTIVE and pulse frame_start_o;
    - set bit counter = 0;
    - load the TX shift register (see byte load).
  - ACTIVE:
    - On synced SCK rising edge: shift synced mosi into rx_shift[0] and increment the bit counter (3 bits, wraps 7→0).
    - When the counter wraps: next cycle rx_byte_o = the assembled byte and rx_en_o=1 for one cycle; set the byte_done flag.
    - On synced SCK falling edge: if byte_done, do a byte load and clear byte_done; otherwise shift tx_shift left by one.
    - On synced csn rising edge: go to IDLE and pulse frame_end_o.
      - Partial RX bits are discarded; no rx_en_o.
      - Bit counter and byte_done are cleared.
      - CSn deassert has priority over an SCK edge detected in the same cycle.
- Byte load:
  - If the holding register is full: tx_shift = holding, holding becomes empty, tx_ready_o goes back to 1 next cycle.
  - If empty: tx_shift = IDLE_BYTE, and tx_underrun_o pulses.
- TX handshake:
  - tx_en_i with tx_ready_o=1 captures tx_byte_i; tx_ready_o=0 from the next cycle.
  - tx_en_i while tx_ready_o=0 is ignored.
  - If tx_en_i and a byte load occur in the same cycle with the holding register empty: the load takes IDLE_BYTE, and the new byte stays in the holding register for the next load.
  - The holding register is kept across frame ends.
- MISO outputs (registered):
  - spi_miso_o = tx_shift[7] while ACTIVE, 0 otherwise.
  - spi_miso_drive_o = sel_o = (state==ACTIVE).
  - The first MSB is valid 1 cycle after frame_start_o, well before the first SCK rising edge given the timing requirement.
- Reset asserted mid-frame: everything returns to reset values immediately, the state becomes WAIT_HIGH, and any byte in the holding register is lost.

Test Plan:
- Reset: check all outputs hold their reset values. Hold CSn low through reset release, then toggle SCK 8 times → no rx_en_o, sel_o=0, spi_miso_drive_o=0.
- Single byte: tx_en_i with 8'hA5 while idle; host sends 8'h3C at 4-clk SCK half-period.
  - Host samples 8'hA5.
  - rx_byte_o=8'h3C with exactly one rx_en_o pulse.
  - frame_start_o and frame_end_o pulse once each; tx_ready_o returns to 1 after the load.
- Back-to-back: preload 8'h12, write 8'h34 as soon as tx_ready_o rises; host sends 8'hC0,8'h0F → host receives 8'h12,8'h34; rx_en_o pulses twice with 8'hC0 then 8'h0F.
- Underrun: preload 8'h55 only, 2-byte frame → host receives 8'h55,8'hFF; tx_underrun_o pulses exactly once, at the second load.
- Abort: CSn rises after 5 SCK cycles → no rx_en_o, frame_end_o pulse. The next frame sending 8'h81 yields rx_byte_o=8'h81, proving the bit counter was cleared.
- Reset mid-frame, then a normal frame with a held byte 8'h77 written after reset → host receives 8'h77; no stale data is transmitted.
